// File: rtl/clm_sqrt_iter.sv
// Iterative masked square root: N_SQ "square then refresh-reduce" steps on a
// redundant (8+d)-bit GF(2^8) representative, one fresh refresh word per step.
module clm_sqrt_iter #(
  parameter int d    = 2,
  parameter int N_SQ = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7+d:0]           in_data,
  input  logic [d-1:0]           r,
  output logic                   rnd_ack,
  input  logic [6+2*d:0][7:0]    B_ext,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7+d:0]           out_data
);

  localparam int SW = 8 + d;
  localparam int PW = 15 + 2 * d;
  localparam int VW = 7 + 2 * d;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} fsm_t;

  fsm_t            r_state;
  fsm_t            w_state_nxt;
  logic [SW-1:0]   r_acc;
  logic [3:0]      r_cnt;
  logic [SW-1:0]   w_sq;

  // Spread bits to even positions, fold the high half back through B_ext and
  // mask with r: the r terms enter both the low byte and the upper bits, so
  // they cancel modulo P while randomising the representative.
  function automatic logic [SW-1:0] sq_refresh(
    input logic [SW-1:0]         a,
    input logic [d-1:0]          rr,
    input logic [VW-1:0][7:0]    b
  );
    logic [PW-1:0] p;
    logic [VW-1:0] v;
    logic [SW-1:0] t;
    p = '0;
    for (int i = 0; i < SW; i++) p[2*i] = a[i];
    v = {p[PW-1:SW], rr};
    t = '0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < VW; k++)
        t[i] = t[i] ^ (v[k] & b[k][i]);
    for (int j = 0; j < d; j++) t[8+j] = rr[j];
    return p[SW-1:0] ^ t;
  endfunction

  assign w_sq = sq_refresh(r_acc, r, B_ext);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 4'(N_SQ - 1)) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_acc <= in_data;
          r_cnt <= '0;
        end
        S_BUSY: begin
          r_acc <= w_sq;
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign rnd_ack   = (r_state == S_BUSY);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_acc;

endmodule

// File: tb/tb_clm_sqrt_iter.sv
// Bench for clm_sqrt_iter: table vectors, random field checks against a
// GF(2^8) model, an N_SQ=8 build, backpressure and mid-operation reset.
module tb_clm_sqrt_iter;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  logic iv1, ir1, ack1, ov1, ordy1;
  logic iv2, ir2, ack2, ov2, ordy2;
  logic [9:0] din1, dout1, din2, dout2;
  logic [D-1:0] r1, r2;
  logic [6+2*D:0][7:0] bext;
  bit   r_zero;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clm_sqrt_iter #(.d(D), .N_SQ(7)) dut (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(din1),
    .r(r1), .rnd_ack(ack1), .B_ext(bext), .out_valid(ov1),
    .out_ready(ordy1), .out_data(dout1));

  clm_sqrt_iter #(.d(D), .N_SQ(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(din2),
    .r(r2), .rnd_ack(ack2), .B_ext(bext), .out_valid(ov2),
    .out_ready(ordy2), .out_data(dout2));

  // fresh refresh words every cycle
  always @(posedge clk) begin
    #1;
    r1 = r_zero ? '0 : D'($urandom);
    r2 = D'($urandom);
  end

  function automatic logic [7:0] gf_red(input logic [31:0] v);
    logic [31:0] w = v;
    for (int b = 31; b >= 8; b--)
      if (w[b]) w = w ^ (32'h11B << (b - 8));
    return w[7:0];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [31:0] pr = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) pr = pr ^ ({24'b0, a} << i);
    return gf_red(pr);
  endfunction

  function automatic logic [7:0] gf_pow2n(input logic [7:0] a, input int n);
    logic [7:0] x = a;
    for (int i = 0; i < n; i++) x = gf_mul(x, x);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit sel, input logic [9:0] x, output logic [9:0] res,
                        output int lat, output int acks);
    if (sel) begin iv2 = 1'b1; din2 = x; end
    else begin iv1 = 1'b1; din1 = x; end
    @(posedge clk); #1;
    iv1 = 1'b0; iv2 = 1'b0;
    lat = 0; acks = 0;
    while (!(sel ? ov2 : ov1) && lat < 40) begin
      if (sel ? ack2 : ack1) acks++;
      @(posedge clk); #1;
      lat++;
    end
    res = sel ? dout2 : dout1;
    if (sel) ordy2 = 1'b1; else ordy1 = 1'b1;
    @(posedge clk); #1;
    ordy1 = 1'b0; ordy2 = 1'b0;
  endtask

  typedef struct {
    logic [9:0] din;
    bit         rz;
    logic [7:0] exp_red;
  } vec_t;

  vec_t vecs[9];
  logic [9:0] ra, rb, x, hold;
  int lat, acks;

  initial begin
    // sqrt is GF(2)-linear; expectations are roots of squares and of x^8.
    vecs[0] = '{10'h000, 1'b1, 8'h00};
    vecs[1] = '{10'h001, 1'b1, 8'h01};
    vecs[2] = '{10'h004, 1'b0, 8'h02};
    vecs[3] = '{10'h010, 1'b0, 8'h04};
    vecs[4] = '{10'h040, 1'b1, 8'h08};
    vecs[5] = '{10'h055, 1'b0, 8'h0F};
    vecs[6] = '{10'h011, 1'b0, 8'h05};
    vecs[7] = '{10'h100, 1'b0, 8'h10};
    vecs[8] = '{10'h11B, 1'b0, 8'h00};

    for (int k = 0; k <= 6 + 2*D; k++) bext[k] = gf_red(32'h1 << (8 + k));
    rst = 1'b1; iv1 = 0; iv2 = 0; ordy1 = 0; ordy2 = 0;
    din1 = '0; din2 = '0; r1 = '0; r2 = '0; r_zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", ov1, 0);
    chk("rst out_data", dout1, 0);
    chk("rst in_ready", ir1, 1);
    chk("rst rnd_ack", ack1, 0);
    rst = 1'b0;

    run_op(0, 10'h000, ra, lat, acks);
    chk("zero out_data", ra, 10'h000);
    chk("zero latency", lat, 7);
    chk("zero rnd_ack cycles", acks, 7);
    run_op(0, 10'h001, ra, lat, acks);
    chk("one out_data", ra, 10'h001);

    for (int i = 0; i < 9; i++) begin
      r_zero = vecs[i].rz;
      run_op(0, vecs[i].din, ra, lat, acks);
      chk($sformatf("vec%0d sqrt", i), gf_red({22'b0, ra}), vecs[i].exp_red);
      chk($sformatf("vec%0d latency", i), lat, 7);
      chk($sformatf("vec%0d acks", i), acks, 7);
    end

    r_zero = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      x = 10'($urandom_range(0, 1023));
      run_op(0, x, ra, lat, acks);
      run_op(0, x, rb, lat, acks);
      chk("rand square back", gf_mul(gf_red({22'b0, ra}), gf_red({22'b0, ra})),
          gf_red({22'b0, x}));
      chk("rand model", gf_red({22'b0, ra}), gf_pow2n(gf_red({22'b0, x}), 7));
      chk("rand r-independence", gf_red({22'b0, ra}), gf_red({22'b0, rb}));
    end

    for (int i = 0; i < 40; i++) begin
      x = 10'($urandom_range(0, 1023));
      run_op(1, x, ra, lat, acks);
      chk("nsq8 identity", gf_red({22'b0, ra}), gf_red({22'b0, x}));
      chk("nsq8 latency", lat, 8);
    end

    // backpressure: hold result, ignore in_valid while not idle
    x = 10'h2A7;
    iv1 = 1'b1; din1 = x;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp latency", lat, 7);
    hold = dout1;
    for (int c = 0; c < 5; c++) begin
      iv1 = c[0]; din1 = 10'h155;
      @(posedge clk); #1;
      chk("bp out_valid", ov1, 1);
      chk("bp out_data stable", dout1, hold);
      chk("bp in_ready", ir1, 0);
    end
    iv1 = 1'b1; ordy1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; ordy1 = 1'b0;
    chk("bp retire out_valid", ov1, 0);
    chk("bp retire in_ready", ir1, 1);
    chk("bp no accept in DONE", ack1, 0);
    chk("bp value", gf_red({22'b0, hold}), gf_pow2n(gf_red({22'b0, x}), 7));

    // reset in the third BUSY cycle
    iv1 = 1'b1; din1 = 10'h3C5;
    @(posedge clk); #1;
    iv1 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid busy rnd_ack", ack1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst out_valid", ov1, 0);
    chk("midrst out_data", dout1, 0);
    chk("midrst in_ready", ir1, 1);
    chk("midrst rnd_ack", ack1, 0);
    x = 10'h0E3;
    run_op(0, x, ra, lat, acks);
    chk("post-rst latency", lat, 7);
    chk("post-rst acks", acks, 7);
    chk("post-rst value", gf_red({22'b0, ra}), gf_pow2n(gf_red({22'b0, x}), 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clm_sqrt_iter.md
# clm_sqrt_iter

Iterative masked square-root unit for the CLM redundant-representation datapath. It takes one element in `state_t` form: 8+d bits, where index i is the coefficient of x^i. It applies N_SQ successive "square then refresh-reduce" steps, consuming one fresh d-bit refresh polynomial per step. With N_SQ=7 the result is x^128 = sqrt(x) in GF(2^8), held as a redundant (8+d)-bit representative. The block is the inverse direction of the per-cycle squaring stage and sits beside the inversion and exponentiation units. It uses valid/ready handshakes on both sides.

## Interface
- d, default 2: number of redundancy bits; sets the `state_t` width (8+d) and the `red_poly_t` width (d).
- N_SQ, default 7: number of squaring steps per operation, legal range 1..15. 7 gives the square root; 8 gives a refreshed identity.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  high exactly when the state is IDLE.
- in_data  in  8+d  input element (`state_t`).
- r  in  d  fresh refresh polynomial (`red_poly_t`), sampled on every BUSY edge.
- rnd_ack  out  1  high in every cycle in which `r` is consumed (the state is BUSY).
- B_ext  in  `nm_matrix_t`  extended reduction matrix, rows 0..6+2d, columns 0..7; static during operation.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8+d  result element (`state_t`), registered.

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: acc (8+d bits), cnt (4 bits), state.
- IDLE:
  - in_ready=1.
  - On in_valid: acc<=in_data, cnt<=0, go to BUSY.
- BUSY, on each edge:
  - acc<=SQ(acc, r), cnt<=cnt+1.
  - If cnt==N_SQ-1, go to DONE.
  - rnd_ack=1 throughout BUSY.
- DONE:
  - out_valid=1; out_data=acc, held stable.
  - On out_ready: go to IDLE.
  - in_ready=0 (no overlap with a new operation).
- SQ(a, r) is combinational and defined exactly as follows:
  - p is 15+2d bits: p[2i]=a[i] for i=0..7+d; all odd bits are 0.
  - v = {r, p[8+d : 14+2d]}, which is 7+2d bits with r occupying the low indices.
  - For i=0..7: t[i] = XOR over k of (v[k] AND B_ext[k][i]).
  - For j=0..d-1: t[8+j] = r[j].
  - SQ = p[0:7+d] XOR t.
- Arithmetic: all operations are GF(2), XOR/AND only. There is no carry and no width growth beyond 15+2d.
- Correctness invariant: out_data reduced mod P equals in_data^(2^N_SQ) mod P, for any sequence of r values.
- B_ext and r are not registered internally. The caller holds B_ext constant; r must be fresh in every rnd_ack cycle.

## Timing
- Reset (rst=1 at an edge): state<=IDLE, acc<=0, cnt<=0. In the following cycle: out_valid=0, out_data=0, in_ready=1, rnd_ack=0. This holds from any state, including mid-BUSY; no partial result is ever presented.
- Latency: input accepted at edge k → out_valid high in the cycle after edge k+N_SQ. That is N_SQ cycles of BUSY, with exactly N_SQ rnd_ack cycles.
- Throughput: at best one operation per N_SQ+2 cycles (accept, N_SQ BUSY cycles, DONE with out_ready=1).
- in_valid while not IDLE is ignored; the input is neither sampled nor queued.
- out_valid stays high and out_data stays unchanged until out_ready is sampled high. Back-to-back out_ready makes DONE last one cycle.
- in_valid and out_ready both high in DONE: the result retires, and the new input is not accepted in that cycle.
- rst has priority over every handshake on the same edge.

## Test plan
- d=2, N_SQ=7, in_data=0, r=0 every cycle → out_data=0 exactly 7 cycles after accept; rnd_ack high for exactly 7 cycles.
- in_data=1 (only bit 0 set), r=0 → out_data=1 (all upper bits 0).
- 1000 random in_data values with random r per cycle: golden model check that out_data^2 mod P == in_data mod P, and that the result mod P is identical across two runs with different r streams.
- N_SQ=8 parameter build, random r → out_data mod P == in_data mod P (Frobenius identity).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_data stable, in_ready=0, in_valid pulses ignored; the result retires on the edge where out_ready=1.
- Assert rst in the 3rd BUSY cycle → next cycle IDLE with out_valid=0, acc=0, in_ready=1; a subsequent operation completes with correct latency.
